// File: rtl/ipv4_hdr_csum_insert.sv
// IPv4 header checksum inserter: buffers the 5-word header, computes the
// one's-complement checksum, patches word 2 and then forwards the payload.
module ipv4_hdr_csum_insert #(
  parameter int unsigned CHECK_HDR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] s_data,
  input  logic [3:0]  s_keep,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready
);

  typedef enum logic [1:0] {HDR, CALC, EMIT, PASS} state_t;

  state_t      state_q, state_d;
  logic [2:0]  hcnt_q, hcnt_d;
  logic [2:0]  eidx_q, eidx_d;
  logic [15:0] acc_hi_q, acc_hi_d;
  logic [15:0] acc_lo_q, acc_lo_d;
  logic [15:0] csum_q, csum_d;
  logic        patch_q, patch_d;
  logic        short_q, short_d;
  logic        last_q, last_d;
  logic        m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;
  logic [3:0]  m_keep_q, m_keep_d;
  logic        m_last_q, m_last_d;

  logic [31:0] hbuf_q  [5];
  logic [3:0]  hkeep_q [5];

  logic        hdr_wr;
  logic [31:0] s_masked;
  logic [2:0]  nidx;

  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  assign s_masked = s_data & {{8{s_keep[3]}}, {8{s_keep[2]}}, {8{s_keep[1]}}, {8{s_keep[0]}}};
  assign nidx     = eidx_q + 3'd1;

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    eidx_d    = eidx_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    csum_d    = csum_q;
    patch_d   = patch_q;
    short_d   = short_q;
    last_d    = last_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
    hdr_wr    = 1'b0;

    case (state_q)
      HDR: begin
        if (s_valid) begin
          hdr_wr   = 1'b1;
          acc_hi_d = ones_add(acc_hi_q, s_masked[31:16]);
          // checksum field itself contributes zero
          acc_lo_d = ones_add(acc_lo_q, (hcnt_q == 3'd2) ? 16'h0000 : s_masked[15:0]);
          hcnt_d   = hcnt_q + 3'd1;
          last_d   = s_last;
          short_d  = s_last && (hcnt_q != 3'd4);
          if (s_last || hcnt_q == 3'd4) begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        csum_d    = ~ones_add(acc_hi_q, acc_lo_q);
        patch_d   = !short_q &&
                    ((CHECK_HDR == 0) ||
                     (hbuf_q[0][31:28] == 4'h4 && hbuf_q[0][27:24] == 4'h5));
        eidx_d    = '0;
        m_valid_d = 1'b1;
        m_data_d  = hbuf_q[0];
        m_keep_d  = hkeep_q[0];
        m_last_d  = last_q && (hcnt_q == 3'd1);
        state_d   = EMIT;
      end

      EMIT: begin
        if (m_ready) begin
          if (eidx_q == hcnt_q - 3'd1) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            if (last_q) begin
              hcnt_d   = '0;
              acc_hi_d = '0;
              acc_lo_d = '0;
              state_d  = HDR;
            end else begin
              state_d  = PASS;
            end
          end else begin
            eidx_d   = nidx;
            m_data_d = (nidx == 3'd2 && patch_q) ? {hbuf_q[2][31:16], csum_q} : hbuf_q[nidx];
            m_keep_d = hkeep_q[nidx];
            m_last_d = last_q && (nidx == hcnt_q - 3'd1);
          end
        end
      end

      PASS: begin
        if (s_valid && m_ready && s_last) begin
          hcnt_d   = '0;
          acc_hi_d = '0;
          acc_lo_d = '0;
          state_d  = HDR;
        end
      end

      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HDR;
      hcnt_q    <= '0;
      eidx_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      csum_q    <= '0;
      patch_q   <= 1'b0;
      short_q   <= 1'b0;
      last_q    <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_keep_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      eidx_q    <= eidx_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      csum_q    <= csum_d;
      patch_q   <= patch_d;
      short_q   <= short_d;
      last_q    <= last_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_keep_q  <= m_keep_d;
      m_last_q  <= m_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (hdr_wr) begin
      hbuf_q[hcnt_q]  <= s_masked;
      hkeep_q[hcnt_q] <= s_keep;
    end
  end

  // payload phase is a straight wire; header phase uses the registered beat
  assign s_ready = (state_q == HDR) || (state_q == PASS && m_ready);
  assign m_valid = (state_q == PASS) ? s_valid : m_valid_q;
  assign m_data  = (state_q == PASS) ? s_data  : m_data_q;
  assign m_keep  = (state_q == PASS) ? s_keep  : m_keep_q;
  assign m_last  = (state_q == PASS) ? s_last  : m_last_q;

endmodule

// File: tb/tb_ipv4_hdr_csum_insert.sv
// Directed bench: per-beat {input, expected output} records streamed through
// the inserter, plus hand sequences for latency, backpressure and reset.
module tb_ipv4_hdr_csum_insert;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_keep;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;

  always #5 clk = ~clk;

  ipv4_hdr_csum_insert #(.CHECK_HDR(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_data  (s_data),
    .s_keep  (s_keep),
    .s_valid (s_valid),
    .s_last  (s_last),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_keep  (m_keep),
    .m_valid (m_valid),
    .m_last  (m_last),
    .m_ready (m_ready)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic [31:0] d, input logic [3:0] k, input logic l,
                              input logic [31:0] ed, input logic [3:0] ek, input logic el);
    vec_t v;
    v.d = d; v.k = k; v.l = l; v.ed = ed; v.ek = ek; v.el = el;
    vecs.push_back(v);
  endfunction

  function automatic void add_hdr(input logic [31:0] w0, input logic [31:0] w2e, input logic l4);
    add(w0,           4'hF, 1'b0, w0,           4'hF, 1'b0);
    add(32'h00004000, 4'hF, 1'b0, 32'h00004000, 4'hF, 1'b0);
    add(32'h4011FFFF, 4'hF, 1'b0, w2e,          4'hF, 1'b0);
    add(32'hC0A80001, 4'hF, 1'b0, 32'hC0A80001, 4'hF, 1'b0);
    add(32'hC0A800C7, 4'hF, l4,   32'hC0A800C7, 4'hF, l4);
  endfunction

  // Streams vecs[lo..hi) in and checks the same number of beats out.
  task automatic run(input int lo, input int hi, input bit bp, output int lat);
    int          in_i;
    int          out_i;
    int          cyc;
    int          acc5;
    bit          stalled;
    logic [31:0] hold_d;
    logic [3:0]  hold_k;
    logic        hold_l;
    in_i = lo; out_i = lo; cyc = 0; acc5 = -1; stalled = 0; lat = -1;
    hold_d = '0; hold_k = '0; hold_l = 1'b0;
    while ((in_i < hi || out_i < hi) && cyc < 400) begin
      @(negedge clk);
      m_ready = bp ? ~cyc[0] : 1'b1;
      if (in_i < hi) begin
        s_valid = 1'b1;
        s_data  = vecs[in_i].d;
        s_keep  = vecs[in_i].k;
        s_last  = vecs[in_i].l;
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (stalled) begin
        check("stall_valid", {31'd0, m_valid}, 32'd1);
        check("stall_data", m_data, hold_d);
        check("stall_keep_last", {27'd0, m_keep, m_last}, {27'd0, hold_k, hold_l});
      end
      stalled = m_valid && !m_ready;
      hold_d = m_data; hold_k = m_keep; hold_l = m_last;
      if (m_valid && m_ready) begin
        if (out_i < hi) begin
          check($sformatf("beat%0d_data", out_i), m_data, vecs[out_i].ed);
          check($sformatf("beat%0d_keep", out_i), {28'd0, m_keep}, {28'd0, vecs[out_i].ek});
          check($sformatf("beat%0d_last", out_i), {31'd0, m_last}, {31'd0, vecs[out_i].el});
          if (out_i == lo && acc5 >= 0) lat = cyc - acc5;
          out_i++;
        end else begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %h expected none", m_data);
        end
      end
      if (s_valid && s_ready) begin
        if (in_i == lo + 4) acc5 = cyc;
        in_i++;
      end
      cyc++;
    end
    checks++;
    if (in_i < hi || out_i < hi) begin
      errors++;
      $display("FAIL timeout: got in=%0d out=%0d expected %0d", in_i, out_i, hi);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    m_ready = 1'b1;
  endtask

  localparam int P_NOM   = 0;   // 6 beats
  localparam int P_VER   = 6;   // 6 beats
  localparam int P_SHORT = 12;  // 3 beats
  localparam int P_ONE   = 15;  // 1 beat
  localparam int P_ZERO  = 16;  // 6 beats
  localparam int P_LAST4 = 22;  // 5 beats
  localparam int P_PAY   = 27;  // 7 beats
  localparam int P_B2B   = 34;  // 12 beats
  localparam int P_END   = 46;

  initial begin
    int lat;
    int sent;
    int cyc;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; m_ready = 1'b1;

    add_hdr(32'h45000073, 32'h4011B861, 1'b0);
    add(32'hDEADBEEF, 4'hF, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1);
    add_hdr(32'h46000073, 32'h4011FFFF, 1'b0);
    add(32'hDEADBEEF, 4'hF, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1);
    add(32'h45000073, 4'hF, 1'b0, 32'h45000073, 4'hF, 1'b0);
    add(32'h00004000, 4'hF, 1'b0, 32'h00004000, 4'hF, 1'b0);
    add(32'h4011FFFF, 4'hC, 1'b1, 32'h40110000, 4'hC, 1'b1);
    add(32'h45000073, 4'hF, 1'b1, 32'h45000073, 4'hF, 1'b1);
    add(32'h45000000, 4'hF, 1'b0, 32'h45000000, 4'hF, 1'b0);
    add(32'h00000000, 4'hF, 1'b0, 32'h00000000, 4'hF, 1'b0);
    add(32'h00001234, 4'hF, 1'b0, 32'h00000000, 4'hF, 1'b0);
    add(32'h00000000, 4'hF, 1'b0, 32'h00000000, 4'hF, 1'b0);
    add(32'hBAFF0000, 4'hF, 1'b0, 32'hBAFF0000, 4'hF, 1'b0);
    add(32'h11223344, 4'hF, 1'b1, 32'h11223344, 4'hF, 1'b1);
    add_hdr(32'h45000073, 32'h4011B861, 1'b1);
    add_hdr(32'h45000073, 32'h4011B861, 1'b0);
    add(32'hAABBCCDD, 4'hF, 1'b0, 32'hAABBCCDD, 4'hF, 1'b0);
    add(32'h11223344, 4'h8, 1'b1, 32'h11223344, 4'h8, 1'b1);
    add_hdr(32'h45000073, 32'h4011B861, 1'b0);
    add(32'hDEADBEEF, 4'hF, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1);
    add_hdr(32'h45000073, 32'h4011B861, 1'b0);
    add(32'hDEADBEEF, 4'hF, 1'b1, 32'hDEADBEEF, 4'hF, 1'b1);
    if (vecs.size() != P_END) $display("vector table size %0d", vecs.size());

    repeat (3) @(negedge clk);
    #1;
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_last", {31'd0, m_last}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("s_ready_after_rst", {31'd0, s_ready}, 32'd1);

    run(P_NOM, P_NOM + 6, 1'b0, lat);
    check("latency", lat, 32'd2);
    run(P_VER, P_VER + 6, 1'b0, lat);
    run(P_SHORT, P_B2B, 1'b0, lat);
    run(P_NOM, P_NOM + 6, 1'b1, lat);
    run(P_B2B, P_END, 1'b0, lat);

    // Abort a packet while its header is being emitted under backpressure.
    m_ready = 1'b0;
    sent = 0; cyc = 0;
    while (sent < 5 && cyc < 50) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = vecs[P_NOM + sent].d;
      s_keep  = vecs[P_NOM + sent].k;
      s_last  = vecs[P_NOM + sent].l;
      #1;
      if (s_ready) sent++;
      cyc++;
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    cyc = 0;
    while (!m_valid && cyc < 10) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    check("emit_reached", {31'd0, m_valid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_m_valid", {31'd0, m_valid}, 32'd0);
    check("abort_m_last", {31'd0, m_last}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ready = 1'b1;
    #1;
    check("abort_s_ready", {31'd0, s_ready}, 32'd1);
    run(P_NOM, P_NOM + 6, 1'b0, lat);
    check("latency_after_abort", lat, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
